booth_product_accumulator: RTL

BOOTH_PRODUCT_ACCUMULATOR -- requirements
Module: booth_product_accumulator

---
 rtl/booth_pkg.sv | 21 ++
 rtl/booth_sat_adder.sv | 34 +++
 rtl/booth_product_accumulator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared Booth types: FSM state encodings and product/accumulator width helpers.
// Used by the multiplier and by the product accumulator.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_t;

  // Product width for operands of 2**n bits.
  function automatic int pw_width(input int n);
    return 1 << (n + 1);
  endfunction

  // Accumulator width: product width plus guard bits.
  function automatic int aw_width(input int n, input int guard);
    return (1 << (n + 1)) + guard;
  endfunction

endpackage

// File: rtl/booth_sat_adder.sv
// Sign-extends a product, adds it to the accumulator and flags signed overflow.
// Combinational. Clamps on overflow when ACC_SATURATE_EN is defined, otherwise wraps.
module booth_sat_adder #(
  parameter int PW = 8,
  parameter int AW = 12
) (
  input  logic [AW-1:0] acc_in,
  input  logic [PW-1:0] product,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  logic [AW-1:0] ext;
  logic [AW-1:0] raw;

  // AW > PW always holds because there is at least one guard bit.
  assign ext = {{(AW-PW){product[PW-1]}}, product};
  assign raw = acc_in + ext;

  // Same-sign operands producing an opposite-sign result.
  assign ovf = (acc_in[AW-1] == ext[AW-1]) && (raw[AW-1] != acc_in[AW-1]);

`ifdef ACC_SATURATE_EN
  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = acc_in[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums pCnt Booth products per frame; result appears the cycle after the final Valid.
// Holds the frame until Out_Valid && Out_Ready; Valids seen while holding set Drop. ACC_SATURATE_EN selects clamping.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int pN     = 2,
  parameter int pCnt   = 4,
  parameter int pGuard = 4
) (
  input  logic                             Clk,
  input  logic                             Rst_n,
  input  logic                             Clr,
  input  logic                             Valid,
  input  logic [pw_width(pN)-1:0]          Product,
  output logic                             Out_Valid,
  input  logic                             Out_Ready,
  output logic [aw_width(pN, pGuard)-1:0]  Sum,
  output logic                             Ovf,
  output logic                             Drop
);

  localparam int PW = pw_width(pN);
  localparam int AW = aw_width(pN, pGuard);
  localparam logic [7:0] CNT_LAST = 8'(pCnt);

  acc_state_t state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic          ovf_q, ovf_nxt;
  logic          drop_q, drop_nxt;

  logic          handshake;
  logic [AW-1:0] add_in;
  logic [AW-1:0] add_sum;
  logic          add_ovf;
  logic [7:0]    cnt_inc;

  assign handshake = (state == ST_HOLD) && Out_Ready;
  // A product arriving with the handshake starts a new frame from zero.
  assign add_in    = handshake ? '0 : acc;
  assign cnt_inc   = handshake ? 8'd1 : cnt + 8'd1;

  booth_sat_adder #(
    .PW (PW),
    .AW (AW)
  ) u_adder (
    .acc_in  (add_in),
    .product (Product),
    .sum     (add_sum),
    .ovf     (add_ovf)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf_q;
    drop_nxt  = drop_q;
    if (Clr) begin
      state_nxt = ST_IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
      drop_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (Valid) begin
            acc_nxt   = add_sum;
            cnt_nxt   = cnt_inc;
            ovf_nxt   = ovf_q | add_ovf;
            state_nxt = (cnt_inc == CNT_LAST) ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            if (Valid) begin
              acc_nxt   = add_sum;
              cnt_nxt   = cnt_inc;
              ovf_nxt   = add_ovf;
              state_nxt = (cnt_inc == CNT_LAST) ? ST_HOLD : ST_ACCUM;
            end else begin
              acc_nxt   = '0;
              cnt_nxt   = '0;
              ovf_nxt   = 1'b0;
              state_nxt = ST_IDLE;
            end
          end else if (Valid) begin
            drop_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      ovf_q  <= ovf_nxt;
      drop_q <= drop_nxt;
    end
  end

  // Out_Valid decodes registered state only, never Out_Ready.
  assign Out_Valid = (state == ST_HOLD);
  assign Sum       = acc;
  assign Ovf       = ovf_q;
  assign Drop      = drop_q;

endmodule
